unsat_index_mapper: RTL and testbench

Maps a free-running random word onto a uniformly selected index into the unsat clause buffer, computing `rand mod m`, where m is the current unsat-clause count. The mapper sits directly upstream of the reciprocal ROM. It drives the ROM's enable and address with m and consumes the registered 1/m word one cycle later. It then runs a multiply/subtract/correct pipeline and hands the resulting index to the clause-buffer read port.

---
 rtl/unsat_index_mapper.sv | 130 +++++++++++++
 tb/tb_unsat_index_mapper.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/unsat_index_mapper.sv
// rtl/unsat_index_mapper.sv - maps a random word to rand mod m via reciprocal-ROM multiply,
// subtract and a single +/-m correction step.
module unsat_index_mapper #(
    parameter int BUFFER_DEPTH  = 2048,
    parameter int M_TABLE_WIDTH = 32,
    parameter int RAND_WIDTH    = 32,
    localparam int IDX_W        = $clog2(BUFFER_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    output logic                     ready_o,
    input  logic [RAND_WIDTH-1:0]    rand_i,
    input  logic [IDX_W:0]           unsat_count_i,
    output logic                     m_table_en_o,
    output logic [IDX_W:0]           m_table_addr_o,
    input  logic [M_TABLE_WIDTH-1:0] m_table_data_i,
    output logic [IDX_W-1:0]         idx_o,
    output logic                     idx_valid_o,
    output logic                     zero_err_o
);

    localparam int W  = RAND_WIDTH;
    localparam int RW = RAND_WIDTH + 2;
    localparam int PW = RAND_WIDTH + IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MUL,
        S_SUB,
        S_FIX
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [W-1:0]       rand_r;
    logic [IDX_W:0]     m_r;
    logic [W-1:0]       q_r;
    // Two's-complement remainder estimate; MSB set means q overshot by one.
    logic [RW-1:0]      r_r;
    logic [RW-1:0]      m_ext;
    logic [RW-1:0]      r_fix;

    assign m_ext = {{(RW-IDX_W-1){1'b0}}, m_r};

    always_comb begin
        state_nx       = state;
        ready_o        = 1'b0;
        m_table_en_o   = 1'b0;
        m_table_addr_o = '0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_nx = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (m_r != '0) begin
                    m_table_en_o   = 1'b1;
                    m_table_addr_o = m_r;
                end
                state_nx = S_MUL;
            end
            S_MUL:   state_nx = S_SUB;
            S_SUB:   state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        r_fix = r_r;
        if (r_r[RW-1]) begin
            r_fix = r_r + m_ext;
        end else if (r_r >= m_ext) begin
            r_fix = r_r - m_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rand_r      <= '0;
            m_r         <= '0;
            q_r         <= '0;
            r_r         <= '0;
            idx_o       <= '0;
            idx_valid_o <= 1'b0;
            zero_err_o  <= 1'b0;
        end else begin
            state       <= state_nx;
            idx_valid_o <= 1'b0;
            zero_err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rand_r <= rand_i;
                        m_r    <= unsat_count_i;
                    end
                end
                S_MUL: begin
                    // ROM output is undefined when it was not addressed (m=0); keep it out.
                    if (m_r == '0) begin
                        q_r <= '0;
                    end else begin
                        q_r <= W'(({{W{1'b0}}, rand_r} * {{W{1'b0}}, m_table_data_i}) >> W);
                    end
                end
                S_SUB: begin
                    r_r <= {2'b00, rand_r} - RW'({{(IDX_W+1){1'b0}}, q_r} * {{W{1'b0}}, m_r});
                end
                S_FIX: begin
                    idx_valid_o <= 1'b1;
                    if (m_r == '0) begin
                        idx_o      <= '0;
                        zero_err_o <= 1'b1;
                    end else begin
                        idx_o <= IDX_W'(r_fix);
                    end
                end
                default: ;
            endcase
        end
    end

    // Product width bound for the SUB step relies on PW >= RW.
    logic unused_pw_ok;
    assign unused_pw_ok = (PW >= RW);

endmodule

// File: tb/tb_unsat_index_mapper.sv
// tb/tb_unsat_index_mapper.sv - scoreboard bench for unsat_index_mapper against rand % m.
module tb_unsat_index_mapper;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] rand_i = '0;
    logic [11:0] unsat_count_i = '0;
    logic        ready_o;
    logic        m_table_en_o;
    logic [11:0] m_table_addr_o;
    logic [31:0] m_table_data_i = '0;
    logic [10:0] idx_o;
    logic        idx_valid_o;
    logic        zero_err_o;

    unsat_index_mapper dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .ready_o        (ready_o),
        .rand_i         (rand_i),
        .unsat_count_i  (unsat_count_i),
        .m_table_en_o   (m_table_en_o),
        .m_table_addr_o (m_table_addr_o),
        .m_table_data_i (m_table_data_i),
        .idx_o          (idx_o),
        .idx_valid_o    (idx_valid_o),
        .zero_err_o     (zero_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit floor_mode = 1'b0;

    function automatic logic [31:0] rom_val(input logic [11:0] m, input bit fl);
        longint unsigned num;
        longint unsigned mm;
        longint unsigned v;
        num = 64'h1_0000_0000;
        mm  = {52'd0, m};
        if (mm == 0) return 32'd0;
        v = fl ? (num / mm) : ((num + mm - 1) / mm);
        if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
        return v[31:0];
    endfunction

    always @(posedge clk) begin
        if (m_table_en_o) m_table_data_i <= rom_val(m_table_addr_o, floor_mode);
    end

    typedef struct packed {
        logic [10:0] idx;
        logic        zerr;
        logic [11:0] m;
        logic [31:0] acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   en_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("zerr_without_valid", zero_err_o && !idx_valid_o, 0);
                if (m_table_en_o) begin
                    en_cnt++;
                    chk("en_inflight", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        chk("rom_addr", m_table_addr_o, sb[0].m);
                        chk("rom_en_zero_m", sb[0].m == 0, 0);
                    end
                end
                if (idx_valid_o) begin
                    chk("valid_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("idx", idx_o, e.idx);
                        chk("zero_err", zero_err_o, e.zerr);
                        chk("latency", cyc - int'(e.acc), LAT);
                        chk("rom_en_count", en_cnt, (e.m != 0) ? 1 : 0);
                        chk("ready_with_valid", ready_o, 1);
                    end
                    en_cnt = 0;
                end
            end
        end
    endtask

    task automatic req(input logic [31:0] r, input logic [11:0] m, input bit hold,
                       output int waited);
        int n;
        exp_t e;
        longint unsigned rr;
        longint unsigned mm;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 20) begin
            rand_i        = $urandom;
            unsat_count_i = 12'($urandom_range(0, 2048));
            @(negedge clk);
            n++;
        end
        chk("req_ready_timeout", n < 20, 1);
        rr            = {32'd0, r};
        mm            = {52'd0, m};
        rand_i        = r;
        unsat_count_i = m;
        start_i       = 1'b1;
        e.m    = m;
        e.acc  = 32'(cyc + 1);
        e.zerr = (mm == 0);
        e.idx  = (mm == 0) ? 11'd0 : 11'(rr % mm);
        sb.push_back(e);
        waited = n;
        if (!hold) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !ready_o) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            begin : stim
                int w;
                logic [31:0] r;
                logic [11:0] m;
                #1;
                chk("rst_ready", ready_o, 1);
                chk("rst_en", m_table_en_o, 0);
                chk("rst_addr", m_table_addr_o, 0);
                chk("rst_idx", idx_o, 0);
                chk("rst_valid", idx_valid_o, 0);
                chk("rst_zerr", zero_err_o, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;

                req(32'd100, 12'd7, 1'b0, w);
                drain();
                req(32'hFFFF_FFFF, 12'd2048, 1'b0, w);
                req(32'd0, 12'd2048, 1'b0, w);
                req(32'd0, 12'd1, 1'b0, w);
                req(32'd1, 12'd1, 1'b0, w);
                req(32'hFFFF_FFFF, 12'd1, 1'b0, w);
                req(32'd5, 12'd0, 1'b0, w);
                drain();

                req(32'd10, 12'd3, 1'b1, w);
                req(32'd11, 12'd4, 1'b1, w);
                chk("b2b_gap", w, 4);
                req(32'd12, 12'd5, 1'b1, w);
                chk("b2b_gap", w, 4);
                @(negedge clk);
                start_i = 1'b0;
                drain();

                for (int mode = 0; mode < 2; mode++) begin
                    floor_mode = (mode == 1);
                    for (int i = 0; i < 2000; i++) begin
                        m = 12'($urandom_range(1, 2048));
                        case ($urandom_range(0, 7))
                            0:       r = 32'd0;
                            1:       r = 32'hFFFF_FFFF;
                            2:       r = 32'({20'd0, m} * 32'($urandom_range(0, 2097151)));
                            default: r = $urandom;
                        endcase
                        req(r, m, 1'b1, w);
                    end
                    @(negedge clk);
                    start_i = 1'b0;
                    drain();
                end

                // Abort a request while it sits in SUB.
                req(32'd100, 12'd7, 1'b0, w);
                drain();
                req(32'd50, 12'd7, 1'b0, w);
                repeat (2) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("abort_ready", ready_o, 1);
                chk("abort_idx", idx_o, 0);
                chk("abort_valid", idx_valid_o, 0);
                chk("abort_en", m_table_en_o, 0);
                sb.delete();
                en_cnt = 0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (8) @(negedge clk);
                req(32'd9, 12'd4, 1'b0, w);
                drain();
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
